// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: periodically reads a bit-serial temperature sensor
// (MSB first) and presents a 4-bit reading with a one-cycle valid strobe.
// Build macro TEMP_SENSOR_READER_PARITY_EN: the frame carries a fifth,
// even-parity bit; a failed check raises parityError and keeps the old value.
module temp_sensor_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sensorData,
  output logic       sensorCsN,
  output logic       sensorSclk,
  output logic [3:0] tempSensorValue,
  output logic       sampleValid,
  output logic       parityError,
  output logic       busy
);

`ifdef TEMP_SENSOR_READER_PARITY_EN
  localparam int NBITS = 5;
`else
  localparam int NBITS = 4;
`endif

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(NBITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Period counter and one-cycle frame request
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;

  // Frame sequencing
  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_phase;       // current sclk level within a bit
  logic             w_phase_next;
  logic [BIT_W-1:0] r_bit;
  logic [BIT_W-1:0] w_bit_next;

  // Serial capture
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] w_shift_next;
  logic             w_capture;
  logic [3:0]       w_data;
  logic             w_load;

  // Registered outputs and their next values
  logic       r_csn;
  logic       r_sclk;
  logic [3:0] r_value;
  logic       r_valid;
  logic       r_perr;
  logic       r_busy;
  logic       w_csn_next;
  logic       w_sclk_next;
  logic       w_valid_next;
  logic       w_perr_next;
  logic       w_busy_next;

  // Free-running period counter; a request pulses the cycle after the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_req <= 1'b0;
    end else if (!enable) begin
      r_cnt <= '0;
      r_req <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_req <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_req <= 1'b0;
    end
  end

  // Next-state logic: setup delay, N bits of low/high sclk halves, done
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_phase_next = r_phase;
    w_bit_next   = r_bit;
    case (r_state)
      ST_IDLE: begin
        // Requests arriving while a frame runs are simply lost here
        if (r_req) begin
          w_state_next = ST_SETUP;
          w_div_next   = '0;
        end
      end
      ST_SETUP: begin
        if (r_div == DIV_LAST) begin
          w_state_next = ST_SHIFT;
          w_div_next   = '0;
          w_phase_next = 1'b0;
          w_bit_next   = '0;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_next = '0;
          if (!r_phase) begin
            w_phase_next = 1'b1;
          end else if (r_bit == BIT_LAST) begin
            w_state_next = ST_DONE;
            w_phase_next = 1'b0;
          end else begin
            w_phase_next = 1'b0;
            w_bit_next   = r_bit + BIT_W'(1);
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and sequencing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_phase <= w_phase_next;
      r_bit   <= w_bit_next;
    end
  end

  // Sample data in the first cycle of each sclk-high half; output registers
  // are fed from the next-state view, so the result is taken from the
  // post-capture shift value (matters when CLK_DIV is 1)
  always_comb begin
    w_capture    = (r_state == ST_SHIFT) && r_phase && (r_div == '0);
    w_shift_next = r_shift;
    if (w_capture) begin
      w_shift_next = {r_shift[NBITS-2:0], sensorData};
    end
    w_data       = w_shift_next[NBITS-1 -: 4];
    w_csn_next   = !((w_state_next == ST_SETUP) || (w_state_next == ST_SHIFT));
    w_sclk_next  = (w_state_next == ST_SHIFT) && w_phase_next;
    w_valid_next = (w_state_next == ST_DONE);
    w_busy_next  = (w_state_next != ST_IDLE);
`ifdef TEMP_SENSOR_READER_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero
    w_load      = w_valid_next && !(^w_shift_next);
    w_perr_next = w_valid_next && (^w_shift_next);
`else
    w_load      = w_valid_next;
    w_perr_next = 1'b0;
`endif
  end

  // Serial shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_next;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csn   <= 1'b1;
      r_sclk  <= 1'b0;
      r_value <= 4'd0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_csn   <= w_csn_next;
      r_sclk  <= w_sclk_next;
      r_valid <= w_valid_next;
      r_perr  <= w_perr_next;
      r_busy  <= w_busy_next;
      if (w_load) begin
        r_value <= w_data;
      end
    end
  end

  assign sensorCsN       = r_csn;
  assign sensorSclk      = r_sclk;
  assign tempSensorValue = r_value;
  assign sampleValid     = r_valid;
  assign parityError     = r_perr;
  assign busy            = r_busy;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: a default-parameter instance driven by a
// bit-serial sensor model through a table of frames plus reset/enable
// sequences, and a short-period instance for request-dropping behaviour.
module tb_temp_sensor_reader;

`ifdef TEMP_SENSOR_READER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int CD       = 4;
  localparam int SP       = 1000;
  localparam int DONE_OFF = CD * (2 * NB + 1);
  localparam int NV       = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic       rst, enable, sensor_data;
  logic       csn, sclk, valid, perr, busy;
  logic [3:0] value;

  // Short-period instance
  logic       rst_f, en_f, data_f;
  logic       csn_f, sclk_f, valid_f, perr_f, busy_f;
  logic [3:0] value_f;

  temp_sensor_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensorData(sensor_data),
    .sensorCsN(csn), .sensorSclk(sclk), .tempSensorValue(value),
    .sampleValid(valid), .parityError(perr), .busy(busy)
  );

  temp_sensor_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(20)) dut_fast (
    .clk(clk), .rst(rst_f), .enable(en_f), .sensorData(data_f),
    .sensorCsN(csn_f), .sensorSclk(sclk_f), .tempSensorValue(value_f),
    .sampleValid(valid_f), .parityError(perr_f), .busy(busy_f)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / sensor model state for the main instance
  logic       prev_csn  = 1'b1;
  logic       prev_sclk = 1'b0;
  logic [4:0] sensor_word = 5'd0;
  int bit_idx  = 0;
  int t_start  = 0;
  int t_valid  = 0;
  int n_starts = 0;
  int n_valid  = 0;
  int n_rises  = 0;
  int n_falls  = 0;
  int csn_low  = 0;
  int inv_err  = 0;
  int rise_t[8];
  int fall_t[8];

  // Frame monitor plus sensor model: data changes only after sclk falls
  always @(negedge clk) begin
    if (prev_csn && !csn) begin
      t_start = cyc;
      n_starts++;
      n_rises = 0;
      n_falls = 0;
      csn_low = 0;
    end
    if (!csn) csn_low++;
    if (!prev_sclk && sclk) begin
      if (n_rises < 8) rise_t[n_rises] = cyc;
      n_rises++;
    end
    if (prev_sclk && !sclk) begin
      if (n_falls < 8) fall_t[n_falls] = cyc;
      n_falls++;
    end
    if (sclk && csn) inv_err++;
    if (valid) begin
      t_valid = cyc;
      n_valid++;
    end
    if (csn) bit_idx = 0;
    else if (prev_sclk && !sclk) bit_idx++;
    sensor_data = (bit_idx < NB) ? sensor_word[NB-1-bit_idx] : 1'b0;
    prev_csn  = csn;
    prev_sclk = sclk;
  end

  // Short-period instance monitor
  int f_last_valid = -1;
  int f_intervals  = 0;
  int f_bad        = 0;
  int f_inv        = 0;
  logic [3:0] f_value = 4'd0;
  logic       f_perr  = 1'b0;

  always @(negedge clk) begin
    if (valid_f) begin
      if (f_last_valid >= 0) begin
        f_intervals++;
        if (cyc - f_last_valid != 40) f_bad++;
      end
      f_last_valid = cyc;
      f_value = value_f;
      f_perr  = perr_f;
    end
    if (sclk_f && csn_f) f_inv++;
  end

  typedef struct {
    logic [4:0] bits;
    logic [3:0] exp_value;
    logic       exp_perr;
  } vec_t;

  vec_t vec[NV];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int start_n;
    int k;
    start_n = n_valid;
    k = 0;
    while (n_valid == start_n && k < budget) begin
      tick();
      k++;
    end
    if (n_valid == start_n) chk({name, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_start(input int budget, input string name);
    int start_n;
    int k;
    start_n = n_starts;
    k = 0;
    while (n_starts == start_n && k < budget) begin
      tick();
      k++;
    end
    if (n_starts == start_n) chk({name, "_start_timeout"}, 0, 1);
  endtask

  int t_en, prev_valid, t_rf, ts, nv_snap, ns_snap;
  logic [3:0] fast_exp_value;
  logic       fast_exp_perr;

  initial begin
    rst = 1'b1; enable = 1'b0; rst_f = 1'b1; en_f = 1'b0; data_f = 1'b1;

`ifdef TEMP_SENSOR_READER_PARITY_EN
    vec[0] = '{5'b01010, 4'd5,  1'b0};
    vec[1] = '{5'b01110, 4'd5,  1'b1};
    vec[2] = '{5'b11110, 4'd15, 1'b0};
    vec[3] = '{5'b00001, 4'd15, 1'b1};
    fast_exp_value = 4'd0;   // 1111 with parity bit 1 always fails
    fast_exp_perr  = 1'b1;
`else
    vec[0] = '{5'b00101, 4'd5,  1'b0};
    vec[1] = '{5'b01111, 4'd15, 1'b0};
    vec[2] = '{5'b00000, 4'd0,  1'b0};
    vec[3] = '{5'b01010, 4'd10, 1'b0};
    fast_exp_value = 4'd15;
    fast_exp_perr  = 1'b0;
`endif

    repeat (4) tick();
    chk("reset_csn",   csn,   1);
    chk("reset_sclk",  sclk,  0);
    chk("reset_value", value, 0);
    chk("reset_valid", valid, 0);
    chk("reset_perr",  perr,  0);
    chk("reset_busy",  busy,  0);

    sensor_word = vec[0].bits;
    rst = 1'b0; rst_f = 1'b0;
    tick();
    enable = 1'b1; en_f = 1'b1;
    t_en = cyc;

    // Consecutive frames from the table
    prev_valid = 0;
    for (int i = 0; i < NV; i++) begin
      wait_valid(SP + 100, $sformatf("v%0d", i));
      if (i == 0) chk("v0_first_start_latency", t_start - t_en, SP + 1);
      else        chk($sformatf("v%0d_valid_interval", i), t_valid - prev_valid, SP);
      chk($sformatf("v%0d_done_offset", i), t_valid - t_start, DONE_OFF);
      chk($sformatf("v%0d_csn_low_cycles", i), csn_low, DONE_OFF);
      chk($sformatf("v%0d_sclk_pulses", i), n_rises, NB);
      chk($sformatf("v%0d_first_rise", i), rise_t[0] - t_start, 2 * CD);
      chk($sformatf("v%0d_sclk_high", i), fall_t[0] - rise_t[0], CD);
      chk($sformatf("v%0d_sclk_period", i), rise_t[1] - rise_t[0], 2 * CD);
      chk($sformatf("v%0d_value", i), value, vec[i].exp_value);
      chk($sformatf("v%0d_perr", i), perr, vec[i].exp_perr);
      chk($sformatf("v%0d_csn_at_done", i), csn, 1);
      prev_valid = t_valid;
      sensor_word = (i + 1 < NV) ? vec[i+1].bits : 5'b11011;
      tick();
      chk($sformatf("v%0d_valid_one_cycle", i), valid, 0);
      chk($sformatf("v%0d_busy_after_done", i), busy, 0);
    end

    // Reset during the low half of bit 2
    wait_start(SP + 100, "rst_frame");
    ts = t_start;
    while (cyc < ts + 5 * CD + 2) tick();
    chk("busy_before_rst", busy, 1);
    nv_snap = n_valid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t_rf = cyc;
    chk("rst_mid_csn",   csn,   1);
    chk("rst_mid_sclk",  sclk,  0);
    chk("rst_mid_value", value, 0);
    chk("rst_mid_busy",  busy,  0);
    chk("rst_mid_valid", valid, 0);
`ifdef TEMP_SENSOR_READER_PARITY_EN
    sensor_word = 5'b00110;
`else
    sensor_word = 5'b00011;
`endif
    wait_start(SP + 100, "restart");
    chk("restart_latency", t_start - t_rf, SP + 1);
    chk("no_valid_after_rst", n_valid, nv_snap);

    // Drop enable ten cycles into the frame
    while (cyc < t_start + 10) tick();
    enable = 1'b0;
    wait_valid(100, "en_drop");
    chk("en_drop_done_offset", t_valid - t_start, DONE_OFF);
    chk("en_drop_value", value, 3);
    ns_snap = n_starts;
    repeat (3000) tick();
    chk("no_frames_after_disable", n_starts, ns_snap);
    chk("idle_csn_after_disable", csn, 1);
    chk("idle_busy_after_disable", busy, 0);
    chk("main_sclk_with_csn_high", inv_err, 0);

    // Short-period instance: every second request is dropped
    chk("fast_interval_errors", f_bad, 0);
    chk("fast_enough_frames", (f_intervals >= 150) ? 1 : 0, 1);
    chk("fast_sclk_with_csn_high", f_inv, 0);
    chk("fast_value", f_value, fast_exp_value);
    chk("fast_perr", f_perr, fast_exp_perr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

Serial front-end that periodically reads a bit-serial temperature sensor and delivers a 4-bit reading to the temperature abnormality detector. It drives the sensor's chip-select and serial clock, shifts in the reading MSB first, and presents it as `tempSensorValue` with a one-cycle `sampleValid` strobe. It sits between the sensor pins and the detector's `tempSensorValue` input.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sensorSclk` half-period; must be ≥1.
- `SAMPLE_PERIOD`, 1000: `clk` cycles between frame starts; must be ≥ frame length + 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  periodic reading enabled.
- `sensorData`  in  1  serial data from the sensor; sensor updates it after `sensorSclk` falls.
- `sensorCsN`  out  1  sensor chip-select, active low.
- `sensorSclk`  out  1  sensor serial clock; idles low.
- `tempSensorValue`  out  4  last valid reading, to the detector.
- `sampleValid`  out  1  one-cycle strobe: the reading is complete.
- `parityError`  out  1  one-cycle strobe with `sampleValid`: the parity check failed.
- `busy`  out  1  a frame is in progress.

## Operation
- All outputs are registered. Reset values: `sensorCsN`=1, `sensorSclk`=0, `tempSensorValue`=0, `sampleValid`=0, `parityError`=0, `busy`=0. The period counter resets to 0 and the state to IDLE.
- Period counter `cnt`:
  - While `enable`=1, `cnt` increments each cycle.
  - At `cnt`==`SAMPLE_PERIOD`-1, `cnt` wraps to 0 and a frame request is raised.
  - While `enable`=0, `cnt` is held at 0.
- States:
  - IDLE: a frame request moves to SETUP.
  - SETUP: `sensorCsN`=0 and `sensorSclk`=0 for `CLK_DIV` cycles, then SHIFT.
  - SHIFT: N bits. Each bit is `CLK_DIV` cycles with `sensorSclk` low, then `CLK_DIV` cycles with `sensorSclk` high. `sensorData` is captured in the cycle `sensorSclk` goes 0→1. After bit N-1 completes, go to DONE.
  - DONE: one cycle. `sensorCsN`=1, `sensorSclk`=0, `sampleValid`=1, result latched. Then IDLE.
- Bits are shifted MSB first. N=4, or N=5 with parity (see Configuration).
- `busy`=1 in SETUP, SHIFT and DONE.
- A frame request raised while `busy`=1 is dropped; no queueing.
- `enable` falling mid-frame: the frame completes normally, and no new request follows.
- `rst` mid-frame: the frame is aborted immediately, all outputs take their reset values, and no `sampleValid` is produced.
- `sensorSclk` is 0 whenever `sensorCsN`=1.

## Timing
- Frame start T = first cycle of SETUP = the cycle after `cnt` wraps.
- First frame starts `SAMPLE_PERIOD`+1 cycles after `enable` rises.
- `sensorCsN` falls at T.
- Bit i: `sensorSclk` rises at T + `CLK_DIV`·(2i+2) and falls at T + `CLK_DIV`·(2i+3).
- DONE at T + `CLK_DIV`·(2N+1): `sampleValid` high, and `tempSensorValue` updated the same cycle.
- Defaults: DONE at T+36 (N=4), or T+44 (N=5).
- Frame length = `CLK_DIV`·(2N+1)+1 cycles.
- `sensorSclk` period = 2·`CLK_DIV` cycles at 50% duty.

## Configuration
- Macro `TEMP_SENSOR_READER_PARITY_EN`.
- Defined:
  - N=5; the fifth bit is an even-parity bit over the 4 data bits.
  - On mismatch: `parityError`=1 with `sampleValid`, and `tempSensorValue` keeps its previous value.
  - On match: `tempSensorValue` is updated.
- Undefined:
  - N=4, with no parity logic.
  - `parityError` is constant 0, and every frame updates `tempSensorValue`.

## Test plan
- Defaults, no parity, sensor model returns 4'b0101 → `sensorCsN` low T..T+35; 4 `sensorSclk` pulses of period 8; at T+36 `sampleValid`=1 for one cycle, `tempSensorValue`=4'b0101, `sensorCsN`=1.
- Consecutive frames returning 4'b1111 then 4'b0000 → two `sampleValid` pulses exactly 1000 cycles apart, values 15 then 0.
- Parity build: 4'b0101 with parity bit 0 → `tempSensorValue`=5, `parityError`=0. Then 4'b0111 with parity bit 0 → `parityError`=1 with `sampleValid`, and `tempSensorValue` stays 5.
- `rst` for one cycle during SHIFT bit 2 → next cycle `sensorCsN`=1, `sensorSclk`=0, `tempSensorValue`=0, `busy`=0, and no `sampleValid`. With `enable` held high, the next frame starts 1001 cycles after `rst` falls.
- `enable` dropped at T+10 → the frame completes with `sampleValid` at T+36, and no further `sensorCsN` activity over 3000 cycles.
- `SAMPLE_PERIOD`=20, `CLK_DIV`=4 (frame 37 cycles) → every second request is dropped, giving `sampleValid` every 40 cycles; `sensorSclk` never high while `sensorCsN`=1.
